// File: rtl/alu_dispatch_if.sv
// Handshake bundle between a requester and the ALU dispatcher: request, unit results
// coming back, and the dispatcher's status/result outputs.
interface alu_dispatch_if #(
    parameter int OUT_WIDTH = 8,
    parameter int NUM_UNITS = 4,
    parameter int SEL_WIDTH = 2
);
    logic                           alu_en;
    logic [SEL_WIDTH-1:0]           unit_sel;
    logic [NUM_UNITS*OUT_WIDTH-1:0] unit_out;
    logic [NUM_UNITS-1:0]           unit_valid;
    logic [NUM_UNITS-1:0]           unit_en;
    logic [OUT_WIDTH-1:0]           alu_out;
    logic                           out_valid;
    logic                           busy;
    logic                           timeout_err;
    logic                           sel_err;

    modport master (
        output alu_en, unit_sel, unit_out, unit_valid,
        input  unit_en, alu_out, out_valid, busy, timeout_err, sel_err
    );

    modport slave (
        input  alu_en, unit_sel, unit_out, unit_valid,
        output unit_en, alu_out, out_valid, busy, timeout_err, sel_err
    );
endinterface

// File: rtl/alu_dispatch.sv
// Two-state dispatcher: forwards one request to a selected functional unit, waits for its
// valid (bounded by TIMEOUT cycles) and registers the returned result.
module alu_dispatch #(
    parameter int OUT_WIDTH = 8,
    parameter int NUM_UNITS = 4,
    parameter int SEL_WIDTH = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          rst,
    alu_dispatch_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [SEL_WIDTH:0] NUM_U = (SEL_WIDTH + 1)'(NUM_UNITS);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state;
    logic [SEL_WIDTH-1:0] sel_q;
    logic [CNT_W-1:0]     cnt;
    logic [OUT_WIDTH-1:0] alu_out_q;
    logic                 out_valid_q;
    logic                 timeout_err_q;
    logic                 sel_err_q;

    logic                 req_ok;
    logic                 sel_valid;
    logic [OUT_WIDTH-1:0] sel_data;
    logic [NUM_UNITS-1:0] unit_en_d;

    assign req_ok = ({1'b0, bus.unit_sel} < NUM_U);

    // Explicit mux over existing units keeps out-of-range sel_q values from indexing past the bus
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        unit_en_d = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (sel_q == SEL_WIDTH'(i)) begin
                sel_valid    = bus.unit_valid[i];
                sel_data     = bus.unit_out[i*OUT_WIDTH +: OUT_WIDTH];
                unit_en_d[i] = (state == WAIT);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sel_q         <= '0;
            cnt           <= '0;
            alu_out_q     <= '0;
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            out_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sel_err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.alu_en) begin
                        if (req_ok) begin
                            sel_q <= bus.unit_sel;
                            cnt   <= '0;
                            state <= WAIT;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // A valid arriving on the last allowed cycle still beats the timeout
                    if (sel_valid) begin
                        alu_out_q   <= sel_data;
                        out_valid_q <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt == LAST) begin
                        timeout_err_q <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.unit_en     = unit_en_d;
    assign bus.alu_out     = alu_out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = (state == WAIT);
    assign bus.timeout_err = timeout_err_q;
    assign bus.sel_err     = sel_err_q;
endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: directed operations push expected completions,
// a negedge monitor pops them whenever a result or timeout pulse appears.
module tb_alu_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_dispatch_if #(.OUT_WIDTH(8), .NUM_UNITS(4), .SEL_WIDTH(2)) ifc ();
    alu_dispatch_if #(.OUT_WIDTH(8), .NUM_UNITS(3), .SEL_WIDTH(2)) ifc3 ();

    alu_dispatch #(.OUT_WIDTH(8), .NUM_UNITS(4), .SEL_WIDTH(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .bus(ifc.slave));
    alu_dispatch #(.OUT_WIDTH(8), .NUM_UNITS(3), .SEL_WIDTH(2), .TIMEOUT(15)) dut3 (
        .clk(clk), .rst(rst), .bus(ifc3.slave));

    typedef struct {
        bit         tmo;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      {31'b0, ifc.busy}, 0);
        chk({tag, "_unit_en"},   {28'b0, ifc.unit_en}, 0);
        chk({tag, "_alu_out"},   {24'b0, ifc.alu_out}, 0);
        chk({tag, "_pulses"},    {29'b0, ifc.out_valid, ifc.timeout_err, ifc.sel_err}, 0);
    endtask

    // Monitor: every result/timeout/sel pulse must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.out_valid || ifc.timeout_err || ifc.sel_err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_event", {29'b0, ifc.out_valid, ifc.timeout_err, ifc.sel_err}, 0);
                end else begin
                    e = sbq.pop_front();
                    if (e.tmo) begin
                        chk("tmo_pulse", {29'b0, ifc.out_valid, ifc.timeout_err, ifc.sel_err}, 32'b010);
                        chk("tmo_hold_out", {24'b0, ifc.alu_out}, {24'b0, e.data});
                    end else begin
                        chk("res_pulse", {29'b0, ifc.out_valid, ifc.timeout_err, ifc.sel_err}, 32'b100);
                        chk("res_data", {24'b0, ifc.alu_out}, {24'b0, e.data});
                    end
                end
            end
        end
    end

    task automatic push(input bit tmo, input logic [7:0] d);
        exp_t e;
        e.tmo  = tmo;
        e.data = d;
        sbq.push_back(e);
    endtask

    // valid_at: WAIT cycle (1-based) in which the selected unit asserts valid; 0 = never
    task automatic op(input int sel, input int valid_at, input logic [7:0] d,
                      input bit noise, output int cyc);
        cyc = 0;
        @(posedge clk); #1;
        ifc.alu_en     = 1'b1;
        ifc.unit_sel   = sel[1:0];
        ifc.unit_valid = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            ifc.alu_en     = 1'b0;
            ifc.unit_valid = '0;
            if (noise) begin
                ifc.unit_valid[0]    = k[0];
                ifc.unit_valid[3]    = ~k[0];
                ifc.unit_out[7:0]    = 8'h10 + k[7:0];
                ifc.unit_out[31:24]  = 8'h30 + k[7:0];
            end
            ifc.unit_out[sel*8 +: 8] = (k == valid_at) ? d : 8'hEE;
            if (k == valid_at) ifc.unit_valid[sel] = 1'b1;
            @(negedge clk);
            if (k == 1) chk("unit_en_onehot", {28'b0, ifc.unit_en}, 32'd1 << sel);
            if (!ifc.busy) break;
            cyc++;
        end
        ifc.unit_valid = '0;
    endtask

    initial begin
        int cyc;
        ifc.alu_en = 0; ifc.unit_sel = 0; ifc.unit_out = '0; ifc.unit_valid = '0;
        ifc3.alu_en = 0; ifc3.unit_sel = 0; ifc3.unit_out = '0; ifc3.unit_valid = '0;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(negedge clk); rst = 1'b0;

        // Unit 2 valid in its first WAIT cycle
        push(0, 8'hA5);
        op(2, 1, 8'hA5, 0, cyc);
        chk("busy_cycles_fast", cyc, 1);

        // Unit 1 valid after 5 WAIT cycles while units 0 and 3 toggle
        push(0, 8'h5C);
        op(1, 6, 8'h5C, 1, cyc);
        chk("busy_cycles_slow", cyc, 6);
        ifc.unit_out = '0;

        // Unit 3 never answers: timeout after 15 cycles, result held
        push(1, 8'h5C);
        op(3, 0, 8'h00, 0, cyc);
        chk("busy_cycles_timeout", cyc, 15);
        repeat (3) @(negedge clk);
        chk("hold_between_ops", {24'b0, ifc.alu_out}, 32'h5C);

        // Valid on the last counter value wins over timeout
        push(0, 8'h3C);
        op(0, 15, 8'h3C, 0, cyc);
        chk("busy_cycles_edge", cyc, 15);

        // Back-to-back: ALU_EN held high, accepted again right after return
        push(0, 8'h77);
        push(0, 8'h88);
        @(posedge clk); #1;
        ifc.alu_en = 1'b1; ifc.unit_sel = 2'd2; ifc.unit_valid = 4'b0100; ifc.unit_out[23:16] = 8'h77;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.unit_out[23:16] = 8'h88;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_second_busy", {31'b0, ifc.busy}, 1);
        chk("b2b_gap_no_valid", {31'b0, ifc.out_valid}, 0);
        @(posedge clk); #1;
        ifc.alu_en = 1'b0; ifc.unit_valid = '0;
        @(negedge clk);
        chk("b2b_done_idle", {31'b0, ifc.busy}, 0);

        // Reset mid-WAIT, then a request on the first edge after release
        @(posedge clk); #1;
        ifc.alu_en = 1'b1; ifc.unit_sel = 2'd1;
        @(posedge clk); #1;
        ifc.alu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #2 chk_all_zero("midwait_reset");
        @(negedge clk);
        chk_all_zero("midwait_reset_hold");
        rst = 1'b0;
        push(0, 8'h42);
        ifc.alu_en = 1'b1; ifc.unit_sel = 2'd0; ifc.unit_valid = 4'b0001; ifc.unit_out[7:0] = 8'h42;
        @(posedge clk); #1;
        ifc.alu_en = 1'b0;
        @(negedge clk);
        chk("post_reset_accept", {27'b0, ifc.busy, ifc.unit_en}, 32'b10001);
        @(posedge clk); #1;
        ifc.unit_valid = '0;
        repeat (2) @(negedge clk);

        // Three-unit instance: out-of-range select
        @(posedge clk); #1;
        ifc3.alu_en = 1'b1; ifc3.unit_sel = 2'd3;
        @(posedge clk); #1;
        ifc3.alu_en = 1'b0;
        @(negedge clk);
        chk("sel_err_pulse", {31'b0, ifc3.sel_err}, 1);
        chk("sel_err_busy", {31'b0, ifc3.busy}, 0);
        chk("sel_err_unit_en", {29'b0, ifc3.unit_en}, 0);
        @(negedge clk);
        chk("sel_err_one_cycle", {30'b0, ifc3.sel_err, ifc3.busy}, 0);
        @(posedge clk); #1;
        ifc3.alu_en = 1'b1; ifc3.unit_sel = 2'd2; ifc3.unit_valid = 3'b100; ifc3.unit_out[23:16] = 8'h99;
        @(posedge clk); #1;
        ifc3.alu_en = 1'b0;
        @(negedge clk);
        chk("dut3_unit_en", {29'b0, ifc3.unit_en}, 32'b100);
        @(negedge clk);
        chk("dut3_result", {23'b0, ifc3.out_valid, ifc3.alu_out}, 32'h199);
        ifc3.unit_valid = '0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter OUT_WIDTH, default 8: result width of every functional unit and of ALU_OUT.
REQ-002 Parameter NUM_UNITS, default 4: number of attached functional units, range 2..16.
REQ-003 Parameter SEL_WIDTH, default 2: width of UNIT_SEL, with 2**SEL_WIDTH >= NUM_UNITS.
REQ-004 Parameter TIMEOUT, default 15: maximum WAIT cycles before abort, range 1..255.
REQ-005 CLK  input  1  single clock; all state changes on rising edge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 ALU_EN  input  1  operation request, sampled only in IDLE.
REQ-008 UNIT_SEL  input  SEL_WIDTH  index of the target unit, sampled with ALU_EN.
REQ-009 UNIT_OUT  input  NUM_UNITS*OUT_WIDTH  packed unit results; unit i occupies bits [i*OUT_WIDTH +: OUT_WIDTH].
REQ-010 UNIT_VALID  input  NUM_UNITS  per-unit result-valid flags.
REQ-011 UNIT_EN  output  NUM_UNITS  one-hot enable to the selected unit.
REQ-012 ALU_OUT  output  OUT_WIDTH  registered result.
REQ-013 OUT_VALID  output  1  one-cycle pulse marking a new ALU_OUT.
REQ-014 BUSY  output  1  high while an operation is outstanding.
REQ-015 TIMEOUT_ERR  output  1  one-cycle pulse when an operation is aborted on timeout.
REQ-016 SEL_ERR  output  1  one-cycle pulse when a request names a unit >= NUM_UNITS.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and WAIT.
REQ-018 In IDLE, with ALU_EN=1 and UNIT_SEL<NUM_UNITS at a rising edge, the block SHALL latch UNIT_SEL into sel_q, clear the cycle counter and enter WAIT.
REQ-019 In IDLE, with ALU_EN=1 and UNIT_SEL>=NUM_UNITS, the block SHALL stay in IDLE and pulse SEL_ERR for the next cycle; ALU_OUT is unchanged.
REQ-020 UNIT_EN SHALL be decoded from registered state only: one-hot of sel_q in WAIT, all zero in IDLE.
REQ-021 BUSY SHALL equal (state==WAIT).
REQ-022 In WAIT, at an edge where UNIT_VALID[sel_q]=1, the block SHALL register the sel_q slice of UNIT_OUT into ALU_OUT, set OUT_VALID=1 for one cycle and return to IDLE.
REQ-023 UNIT_VALID bits of non-selected units SHALL be ignored at all times.
REQ-024 In WAIT without a valid, at an edge where counter==TIMEOUT-1, the block SHALL pulse TIMEOUT_ERR for one cycle, keep ALU_OUT unchanged and return to IDLE; otherwise the counter SHALL increment by 1.
REQ-025 If valid and counter==TIMEOUT-1 occur in the same cycle, the valid SHALL win: the result is captured and no TIMEOUT_ERR is raised.
REQ-026 ALU_EN in WAIT SHALL be ignored, with no queuing.
REQ-027 ALU_EN sampled in the cycle after a return to IDLE SHALL be accepted, giving a minimum issue interval of 2 cycles for a unit valid in its first WAIT cycle.
REQ-028 Latency SHALL be one edge from the valid sample to ALU_OUT/OUT_VALID; a unit valid in its first WAIT cycle completes 2 edges after the ALU_EN sample.
REQ-029 ALU_OUT SHALL hold the last captured result between operations.
REQ-030 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-031 RST=1 SHALL asynchronously force state=IDLE, sel_q=0, counter=0, ALU_OUT=0, OUT_VALID=0, TIMEOUT_ERR=0 and SEL_ERR=0, giving UNIT_EN=0 and BUSY=0.
REQ-032 A reset asserted mid-WAIT SHALL abort the operation with no OUT_VALID or TIMEOUT_ERR pulse.
REQ-033 After RST deasserts, the first rising edge SHALL be able to accept ALU_EN.

Verification
REQ-034 Defaults; ALU_EN=1 with UNIT_SEL=2; unit 2 drives UNIT_VALID[2]=1 with data 0xA5 in the first WAIT cycle -> UNIT_EN=4'b0100 for 1 cycle; ALU_OUT=0xA5 and OUT_VALID pulses 1 cycle, 2 edges after the request.
REQ-035 UNIT_SEL=1; UNIT_VALID[1] rises after 5 WAIT cycles while UNIT_VALID[0] and UNIT_VALID[3] toggle with other data -> BUSY high for 6 cycles; ALU_OUT=unit 1 data only.
REQ-036 UNIT_SEL=3; no valid -> TIMEOUT_ERR pulses after 15 WAIT cycles; ALU_OUT keeps its prior value; no OUT_VALID.
REQ-037 UNIT_VALID[0] coincides with counter==14 -> OUT_VALID pulses; TIMEOUT_ERR stays 0.
REQ-038 NUM_UNITS=3, UNIT_SEL=3 -> SEL_ERR pulses for 1 cycle; BUSY stays 0; UNIT_EN stays 0.
REQ-039 RST pulsed mid-WAIT, then ALU_EN with UNIT_SEL=0 on the first edge after release -> all outputs 0 during reset; new operation proceeds normally; no stray pulses.
